seg_scan_ctrl: RTL and testbench

Scan controller for the 8-digit multiplexed 7-segment display. It sequences the 3-bit digit select into the 8:1 nibble multiplexer and drives the matching active-low anode, inserting a dead-time blank between digits. It also double-buffers the 32-bit display value so that updates take effect only at frame boundaries, which prevents tearing, and it optionally suppresses leading zeros.

---
 rtl/seg_scan_ctrl.sv | 142 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Scan controller for an 8-digit multiplexed 7-segment display.
// It steps a 3-bit digit select through digits 0..7 and drives the matching
// active-low anode. Each digit slot opens with a blank (dead-time) phase.
// The 32-bit display value is double-buffered so that a new value only
// takes effect at a frame boundary, or at once while the scanner is idle.
// Optional leading-zero blanking keeps the upper zero digits dark.
//
// Ports
//   clk      system clock, rising edge
//   rst_n    synchronous active-low reset
//   enable   1 = scan the display, 0 = dark/idle
//   lz_en    1 = leading-zero blanking on
//   load     single-cycle strobe that captures data_in into the shadow register
//   data_in  new display value; nibble i is digit i
//   value    displayed value, drives the nibble multiplexer data input
//   select   current digit index, drives the nibble multiplexer select
//   an_n     anode enables, active low
//   upd_ack  one-cycle pulse when the shadow register is copied into value
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | display dark, select=0, counter=0; a pending shadow is applied at once
// BLANK | dead time at the start of a slot, all anodes off
// ON    | the selected digit is lit unless it is blanked as a leading zero
module seg_scan_ctrl #(
   parameter int CLK_DIV   = 50000,
   parameter int BLANK_CYC = 500
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        lz_en,
   input  logic        load,
   input  logic [31:0] data_in,
   output logic [31:0] value,
   output logic [2:0]  select,
   output logic [7:0]  an_n,
   output logic        upd_ack
);

   localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
   localparam logic [CW-1:0] SLOT_LAST  = CW'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      ON    = 2'd2
   } state_t;

   state_t         state, state_nx;
   logic [CW-1:0]  cnt, cnt_nx;
   logic [2:0]     sel_nx;
   logic [31:0]    shadow;
   logic           pending;
   logic [31:0]    value_nx;
   logic [7:0]     an_nx;
   logic           frame_end;
   logic           xfer;

   // A digit (other than digit 0) is a leading zero when it and every
   // nibble above it are zero.
   function automatic logic digit_dark(input logic [31:0] v, input logic [2:0] d);
      logic [31:0] upper;
      upper = v >> {d, 2'b00};
      return (d != 3'd0) && (upper == 32'd0);
   endfunction

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      sel_nx    = select;
      frame_end = (state == ON) && (cnt == SLOT_LAST) && (select == 3'd7);

      case (state)
         IDLE: begin
            cnt_nx = '0;
            sel_nx = 3'd0;
            if (enable) state_nx = BLANK;
         end
         BLANK: begin
            cnt_nx = cnt + 1'b1;
            if (cnt == BLANK_LAST) state_nx = ON;
         end
         ON: begin
            if (cnt == SLOT_LAST) begin
               state_nx = BLANK;
               cnt_nx   = '0;
               sel_nx   = select + 3'd1;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
            sel_nx   = 3'd0;
         end
      endcase

      // Dropping enable abandons the slot immediately.
      if (!enable) begin
         state_nx = IDLE;
         cnt_nx   = '0;
         sel_nx   = 3'd0;
      end

      xfer     = pending && ((state == IDLE) || (enable && frame_end));
      value_nx = xfer ? shadow : value;

      // an_n is computed from the post-edge state so that it stays registered
      // and lines up with select/value on the same edge.
      an_nx = 8'hFF;
      if ((state_nx == ON) && !(lz_en && digit_dark(value_nx, sel_nx)))
         an_nx = ~(8'b1 << sel_nx);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         select  <= 3'd0;
         value   <= 32'd0;
         shadow  <= 32'd0;
         pending <= 1'b0;
         upd_ack <= 1'b0;
         an_n    <= 8'hFF;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         select  <= sel_nx;
         value   <= value_nx;
         upd_ack <= xfer;
         an_n    <= an_nx;
         if (load) shadow <= data_in;
         // A load coinciding with a transfer keeps pending set for the new data.
         pending <= load | (pending & ~xfer);
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        lz_en;
   logic        load;
   logic [31:0] data_in;
   logic [31:0] value;
   logic [2:0]  select;
   logic [7:0]  an_n;
   logic        upd_ack;

   seg_scan_ctrl #(.CLK_DIV(8), .BLANK_CYC(2)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (enable),
      .lz_en   (lz_en),
      .load    (load),
      .data_in (data_in),
      .value   (value),
      .select  (select),
      .an_n    (an_n),
      .upd_ack (upd_ack)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  sel;
      logic [7:0]  an;
      logic [31:0] val;
      logic        ack;
   } cyc_t;

   cyc_t        cyc_q[$];
   logic [31:0] ack_q[$];
   int          n_chk  = 0;
   int          n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Monitor: one cycle expectation per negedge while queued, and every
   // upd_ack pulse is matched against the queue of expected transfers.
   always @(negedge clk) begin
      cyc_t e;
      if (cyc_q.size() > 0) begin
         e = cyc_q.pop_front();
         chk("select", {29'd0, select}, {29'd0, e.sel});
         chk("an_n", {24'd0, an_n}, {24'd0, e.an});
         chk("value", value, e.val);
         chk("upd_ack", {31'd0, upd_ack}, {31'd0, e.ack});
      end
      if (upd_ack === 1'b1) begin
         if (ack_q.size() == 0) chk("unexpected_upd_ack", 32'd1, 32'd0);
         else chk("ack_value", value, ack_q.pop_front());
      end
   end

   task automatic push(input logic [2:0] s, input logic [7:0] a, input logic [31:0] v, input logic k);
      cyc_t e;
      e.sel = s; e.an = a; e.val = v; e.ack = k;
      cyc_q.push_back(e);
      if (k) ack_q.push_back(v);
   endtask

   task automatic idle_cycle(input logic [31:0] v);
      @(posedge clk); #1;
      push(3'd0, 8'hFF, v, 1'b0);
   endtask

   // Runs one frame (or part of one) with enable held high.
   // v: value expected during the frame; ack0: a transfer lands on the first edge.
   // Loads of la (and lb when n_ld==2) are issued at slot ld_s, cycle ld_c(+1).
   task automatic scan_frame(input logic [31:0] v, input logic ack0,
                             input int ld_s, input int ld_c, input int n_ld,
                             input logic [31:0] la, input logic [31:0] lb,
                             input int stop_s, input int stop_c);
      logic [7:0] a;
      logic       lit;
      for (int s = 0; s < 8; s++) begin
         for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            load = 1'b0;
            lit = (c >= 2) && !(lz_en && (s >= 1) && ((v >> (4 * s)) == 32'd0));
            a = lit ? ~(8'b1 << s) : 8'hFF;
            push(s[2:0], a, v, (s == 0 && c == 0) ? ack0 : 1'b0);
            if (s == ld_s && c == ld_c) begin load = 1'b1; data_in = la; end
            if (n_ld == 2 && s == ld_s && c == ld_c + 1) begin load = 1'b1; data_in = lb; end
            if (s == stop_s && c == stop_c) return;
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; lz_en = 1'b0; load = 1'b0; data_in = 32'd0;

      // Reset and idle-mode load
      repeat (3) @(posedge clk);
      #1 push(3'd0, 8'hFF, 32'd0, 1'b0);
      rst_n = 1'b1;
      load = 1'b1; data_in = 32'h12345678;
      @(posedge clk); #1;
      load = 1'b0;
      push(3'd0, 8'hFF, 32'd0, 1'b0);
      idle_cycle(32'h12345678);
      cyc_q[cyc_q.size()-1].ack = 1'b1;
      ack_q.push_back(32'h12345678);
      idle_cycle(32'h12345678);

      // Scan sequence, then tear-free load while digit 3 is lit
      enable = 1'b1;
      scan_frame(32'h12345678, 1'b0, -1, 0, 0, 32'd0, 32'd0, 8, 0);
      scan_frame(32'h12345678, 1'b0, 3, 4, 1, 32'hDEADBEEF, 32'd0, 8, 0);
      // Collision: A loads just before the boundary, B on the boundary edge
      scan_frame(32'hDEADBEEF, 1'b1, 7, 6, 2, 32'h00000F05, 32'h00000000, 8, 0);
      lz_en = 1'b1;
      scan_frame(32'h00000F05, 1'b1, -1, 0, 0, 32'd0, 32'd0, 8, 0);
      scan_frame(32'h00000000, 1'b1, -1, 0, 0, 32'd0, 32'd0, 8, 0);
      lz_en = 1'b0;
      scan_frame(32'h00000000, 1'b0, -1, 0, 0, 32'd0, 32'd0, 8, 0);

      // Abort during digit 5 ON, then re-enable from digit 0 BLANK
      scan_frame(32'h00000000, 1'b0, -1, 0, 0, 32'd0, 32'd0, 5, 4);
      enable = 1'b0;
      idle_cycle(32'd0);
      enable = 1'b1;
      scan_frame(32'h00000000, 1'b0, -1, 0, 0, 32'd0, 32'd0, 1, 3);
      enable = 1'b0;
      idle_cycle(32'd0);

      // Reset while a load is pending: nothing transfers
      load = 1'b1; data_in = 32'hCAFE0001;
      idle_cycle(32'd0);
      load = 1'b0; rst_n = 1'b0;
      idle_cycle(32'd0);
      rst_n = 1'b1;
      repeat (3) idle_cycle(32'd0);

      // Load during reset is ignored
      rst_n = 1'b0; load = 1'b1; data_in = 32'h00000055;
      idle_cycle(32'd0);
      rst_n = 1'b1; load = 1'b0;
      repeat (3) idle_cycle(32'd0);

      repeat (2) @(posedge clk);
      #1;
      chk("ack_queue_drained", ack_q.size(), 32'd0);
      chk("cycle_queue_drained", cyc_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
